// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding,
// default frame/timing constants and a counter-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_e;

    localparam int DEF_LEN           = 8;
    localparam int DEF_GAP_TICKS     = 16;
    localparam int DEF_TIMEOUT_TICKS = 255;

    // Width that holds max(a, b) without wrapping; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] winner
);

    int idx;

    // Scan from the farthest offset down to the nearest so the nearest hit lands last.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx[$clog2(N)-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N byte requesters, with a
// baud-tick inter-frame gap and a watchdog for a transmitter that never finishes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N             = 4,
    parameter int len           = DEF_LEN,
    parameter int GAP_TICKS     = DEF_GAP_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             baud_tick,
    input  logic [N-1:0]     req,
    input  logic [N*len-1:0] req_data,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     done,
    output logic             err,
    output logic             busy,
    output logic             tx_en,
    output logic [len-1:0]   tx_data,
    input  logic             tx_done_tick
);

    localparam int IW = $clog2(N);
    localparam int CW = cnt_width(GAP_TICKS, TIMEOUT_TICKS);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  sel_q, sel_d;
    logic [len-1:0] tx_data_q, tx_data_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   done_q, done_d;
    logic           err_q, err_d;
    logic           tx_en_q, tx_en_d;
    logic [CW-1:0]  gap_q, gap_d;
    logic [CW-1:0]  wd_q, wd_d;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic [CW-1:0]  gap_inc, wd_inc;

    rr_picker #(.N(N)) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    assign gap_inc = (gap_q == {CW{1'b1}}) ? gap_q : gap_q + 1'b1;
    assign wd_inc  = (wd_q  == {CW{1'b1}}) ? wd_q  : wd_q  + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        tx_data_d = tx_data_q;
        grant_d   = '0;
        done_d    = '0;
        err_d     = 1'b0;
        tx_en_d   = 1'b0;
        gap_d     = gap_q;
        wd_d      = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d             = pick_idx;
                    tx_data_d         = req_data[int'(pick_idx)*len +: len];
                    grant_d[pick_idx] = 1'b1;
                    state_d           = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_en_d = 1'b1;
                wd_d    = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // Completion is checked first so it beats a same-cycle timeout.
                if (tx_done_tick) begin
                    done_d[sel_q] = 1'b1;
                    ptr_d         = sel_q;
                    gap_d         = '0;
                    state_d       = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
                end else if (baud_tick) begin
                    wd_d = wd_inc;
                    if (wd_inc >= CW'(TIMEOUT_TICKS)) begin
                        err_d   = 1'b1;
                        ptr_d   = sel_q;
                        gap_d   = '0;
                        state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (baud_tick) begin
                    gap_d = gap_inc;
                    if (gap_inc >= CW'(GAP_TICKS)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IW'(N - 1);
            sel_q     <= '0;
            tx_data_q <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            gap_q     <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tx_en_q   <= tx_en_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single uart_tx serializer between N byte requesters. It accepts one byte from the winning requester and issues a one-cycle start pulse to the transmitter. It then waits for tx_done_tick and enforces a programmable inter-frame gap, counted in baud ticks, before the next grant. A watchdog recovers the arbiter if the transmitter never reports completion.

Parameters:
N, 4, number of requesters (2..8)
len, 8, data width per byte, matches uart_tx tx_in
GAP_TICKS, 16, idle baud ticks inserted after each frame (0 = no gap)
TIMEOUT_TICKS, 255, baud ticks allowed in BUSY before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
baud_tick  in  1  one-cycle pulse from baud_generator
req  in  N  per-requester level request; held with data until grant
req_data  in  N*len  requester i byte at [i*len +: len]
grant  out  N  one-hot, one-cycle pulse: byte of requester i captured
done  out  N  one-hot, one-cycle pulse: requester i frame completed
err  out  1  one-cycle pulse: watchdog abort of current frame
busy  out  1  high in every state except IDLE
tx_en  out  1  one-cycle start pulse to uart_tx en
tx_data  out  len  byte to uart_tx tx_in; stable from LAUNCH until next capture
tx_done_tick  in  1  completion pulse from uart_tx

Behaviour:
- Reset (reset=0, async): state=IDLE; grant, done, err, tx_en = 0; tx_data = 0; ptr = N-1, so requester 0 has top priority first; gap and watchdog counters = 0.
- States: IDLE, LAUNCH, BUSY, GAP. Encoding is 2-bit binary.
- IDLE:
  - If |req, the winner w is the first asserted req scanning ptr+1, ptr+2, … modulo N.
  - Registered on this edge: sel<=w, tx_data<=req_data[w], grant[w]<=1, state<=LAUNCH.
  - Grant therefore appears 1 cycle after req is seen in IDLE.
- LAUNCH: tx_en<=1 for exactly one cycle; watchdog cleared; state<=BUSY. tx_done_tick is ignored here.
- BUSY:
  - On tx_done_tick: done[sel]<=1 for one cycle; ptr<=sel; state<=GAP (or IDLE if GAP_TICKS=0).
  - Otherwise, each baud_tick increments the watchdog. When the count reaches TIMEOUT_TICKS: err<=1 for one cycle, no done pulse, ptr<=sel, state<=GAP.
  - tx_done_tick and timeout in the same cycle: completion wins, so done fires and err does not.
- GAP: counts baud_ticks. After GAP_TICKS ticks, state<=IDLE. req is not sampled in GAP.
- Requester protocol:
  - Requester holds req and data stable until its grant pulse.
  - req still high in the cycle after grant is treated as a new byte request and competes in the next IDLE.
  - Dropping req before grant withdraws the request with no side effects.
- Fairness: with all N requesting continuously, grants rotate 0,1,…,N-1,0 with one byte each.
- Ptr updates only on frame end (done or err), never on grant.
- Minimum cycle count between grants equals frame time + GAP_TICKS baud ticks + 2 clk.
- Counter widths are $clog2(max(GAP_TICKS,TIMEOUT_TICKS)+1); counters saturate and never wrap.
- Reset mid-frame: outputs are forced to reset values immediately. The transmitter is reset by the same signal, so no orphan done pulse occurs.
- At most one bit of grant, done, tx_en and err is asserted in any cycle (grant and done are each one-hot or zero).

Decomposition:
- Shared package uart_pkg: state typedef (IDLE, LAUNCH, BUSY, GAP), default len, GAP_TICKS, TIMEOUT_TICKS constants.
- Sub-module rr_picker (combinational): inputs req[N] and ptr; outputs valid and winner index. Reusable for a future RX dispatcher.

Test Plan:
- Single requester: req[2]=1, data=0xA5. Required: grant[2] one cycle later; tx_en pulse next cycle with tx_data=0xA5. On tx_done_tick, done[2] pulses; busy stays high for 16 baud ticks, then drops.
- All four requesting continuously with bytes 0x10..0x13. Required: tx_data sequence 0x10,0x11,0x12,0x13,0x10; no grant while busy.
- Priority rotation: after requester 1 completes, raise req[0] and req[3] together. Required: grant[3] first, then grant[0].
- Watchdog: start a frame and suppress tx_done_tick. Required: err pulses exactly after 255 baud ticks in BUSY; no done pulse; arbiter returns to IDLE after the gap.
- Simultaneous tx_done_tick and timeout expiry. Required: done[sel]=1 and err=0.
- Async reset asserted in BUSY. Required: same-cycle grant/done/tx_en/err=0, busy=0, tx_data=0. After release with req[1],req[0] set, the first grant goes to 0.
